// File: rtl/vga_timing_ctrl_if.sv
// vga_timing_ctrl_if: matrix hand-off between the transform stage (master)
// and the VGA timing block (slave). Valid/ready handshake, one matrix per beat.
interface vga_timing_ctrl_if #(
    parameter int unsigned MTRX_W = 336
);
    logic [MTRX_W-1:0] mtrx_in;
    logic              mtrx_in_valid;
    logic              mtrx_in_ready;

    modport master (
        output mtrx_in,
        output mtrx_in_valid,
        input  mtrx_in_ready
    );

    modport slave (
        input  mtrx_in,
        input  mtrx_in_valid,
        output mtrx_in_ready
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480@60 pixel timing, renderer-latency alignment of the
// sync/colour pins, and a frame-synchronous shadow of the transform matrix.
// Optional macro TEST_PATTERN_EN adds a pattern_sel input that replaces the
// renderer pixel with eight 80-pixel colour bars.
module vga_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIX_LAT  = 1,
    parameter int unsigned MTRX_W   = 336
) (
    input  logic              pclk,
    input  logic              rst,
    vga_timing_ctrl_if.slave  mtrx,
`ifdef TEST_PATTERN_EN
    input  logic              pattern_sel,
`endif
    input  logic [11:0]       vga_data,
    output logic [9:0]        h_cnt,
    output logic [9:0]        v_cnt,
    output logic              VGAvalid,
    output logic              frame_start,
    output logic [MTRX_W-1:0] mtrxOut,
    output logic              hsync,
    output logic              vsync,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic {
        EMPTY,
        PENDING
    } mtrx_state_t;

    logic [9:0]         h_nxt;
    logic [9:0]         v_nxt;
    logic               commit;
    logic               hs_raw;
    logic               vs_raw;
    logic [PIX_LAT-1:0] val_dly;
    logic [PIX_LAT-1:0] hs_dly;
    logic [PIX_LAT-1:0] vs_dly;
    logic [11:0]        pix;
    mtrx_state_t        state;
    logic [MTRX_W-1:0]  pend;

    // Next counter position; every registered decode is taken from this.
    always_comb begin
        h_nxt = h_cnt + 10'd1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end
        commit = (h_nxt == '0) && (v_nxt == V_ACT_C);
    end

    // Counters plus decode registered from the next position, so they line up.
    always_ff @(posedge pclk) begin
        if (rst) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            VGAvalid    <= 1'b0;
            frame_start <= 1'b0;
            hs_raw      <= 1'b1;
            vs_raw      <= 1'b1;
        end else begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            VGAvalid    <= (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
            frame_start <= (h_nxt == '0) && (v_nxt == '0);
            hs_raw      <= !((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST));
            vs_raw      <= !((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST));
        end
    end

    // Delay raw valid/syncs by the renderer latency.
    always_ff @(posedge pclk) begin
        if (rst) begin
            val_dly <= '0;
            hs_dly  <= '1;
            vs_dly  <= '1;
        end else begin
            val_dly[0] <= VGAvalid;
            hs_dly[0]  <= hs_raw;
            vs_dly[0]  <= vs_raw;
            for (int unsigned i = 1; i < PIX_LAT; i++) begin
                val_dly[i] <= val_dly[i-1];
                hs_dly[i]  <= hs_dly[i-1];
                vs_dly[i]  <= vs_dly[i-1];
            end
        end
    end

`ifdef TEST_PATTERN_EN
    logic [9:0]  h_dly [PIX_LAT];
    logic [9:0]  bar_idx;
    logic [11:0] bar_rgb;

    // Horizontal count delayed in step with val_dly, used to place the bars.
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PIX_LAT; i++) h_dly[i] <= '0;
        end else begin
            h_dly[0] <= h_cnt;
            for (int unsigned i = 1; i < PIX_LAT; i++) h_dly[i] <= h_dly[i-1];
        end
    end

    // Bar colour from the delayed count, then choose bars or renderer data.
    always_comb begin
        bar_idx = h_dly[PIX_LAT-1] / 10'd80;
        case (bar_idx)
            10'd0:   bar_rgb = 12'hFFF;
            10'd1:   bar_rgb = 12'hFF0;
            10'd2:   bar_rgb = 12'h0FF;
            10'd3:   bar_rgb = 12'h0F0;
            10'd4:   bar_rgb = 12'hF0F;
            10'd5:   bar_rgb = 12'hF00;
            10'd6:   bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
        pix = pattern_sel ? bar_rgb : vga_data;
    end
`else
    // Pins always carry the renderer pixel.
    always_comb begin
        pix = vga_data;
    end
`endif

    // Pin stage: colour gated by delayed valid, syncs get one matching register.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            hsync <= hs_dly[PIX_LAT-1];
            vsync <= vs_dly[PIX_LAT-1];
            if (val_dly[PIX_LAT-1]) begin
                {vga_r, vga_g, vga_b} <= pix;
            end else begin
                {vga_r, vga_g, vga_b} <= '0;
            end
        end
    end

    // Matrix shadow: capture while EMPTY, publish only at the start of vblank.
    // A capture landing on the commit edge is only possible from EMPTY, so it
    // naturally waits in PENDING for the following vblank.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state              <= EMPTY;
            pend               <= '0;
            mtrxOut            <= '0;
            mtrx.mtrx_in_ready <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (mtrx.mtrx_in_valid) begin
                        pend               <= mtrx.mtrx_in;
                        state              <= PENDING;
                        mtrx.mtrx_in_ready <= 1'b0;
                    end
                end
                PENDING: begin
                    if (commit) begin
                        mtrxOut            <= pend;
                        state              <= EMPTY;
                        mtrx.mtrx_in_ready <= 1'b1;
                    end
                end
                default: begin
                    state              <= EMPTY;
                    mtrx.mtrx_in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: a full-size instance checks the real 640x480 timing over
// its first lines; a shrunken-timing instance runs many frames with random
// pixels, random matrices and mid-frame resets against a position-based model.
module tb_vga_timing_ctrl;

    localparam int MW = 336;

    localparam int S_HA = 40, S_HFP = 6, S_HS = 8, S_HBP = 6;
    localparam int S_VA = 12, S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam int S_LAT = 3;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
    localparam int S_FR = S_HT * S_VT;

    localparam int F_HT = 800, F_VT = 525, F_LAT = 1;

    localparam int N_CYC = 12000;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic        rst_s, rst_f;
    logic [11:0] vga_data;
    logic        psel;

    logic [9:0]    s_h, s_v, f_h, f_v;
    logic          s_vld, s_fs, s_hs, s_vs, f_vld, f_fs, f_hs, f_vs;
    logic [3:0]    s_r, s_g, s_b, f_r, f_g, f_b;
    logic [MW-1:0] s_mo, f_mo;

    vga_timing_ctrl_if #(.MTRX_W(MW)) s_if ();
    vga_timing_ctrl_if #(.MTRX_W(MW)) f_if ();

    vga_timing_ctrl #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .PIX_LAT(S_LAT), .MTRX_W(MW)
    ) dut_s (
        .pclk(pclk), .rst(rst_s), .mtrx(s_if),
`ifdef TEST_PATTERN_EN
        .pattern_sel(psel),
`endif
        .vga_data(vga_data), .h_cnt(s_h), .v_cnt(s_v), .VGAvalid(s_vld),
        .frame_start(s_fs), .mtrxOut(s_mo), .hsync(s_hs), .vsync(s_vs),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
    );

    vga_timing_ctrl dut_f (
        .pclk(pclk), .rst(rst_f), .mtrx(f_if),
`ifdef TEST_PATTERN_EN
        .pattern_sel(psel),
`endif
        .vga_data(vga_data), .h_cnt(f_h), .v_cnt(f_v), .VGAvalid(f_vld),
        .frame_start(f_fs), .mtrxOut(f_mo), .hsync(f_hs), .vsync(f_vs),
        .vga_r(f_r), .vga_g(f_g), .vga_b(f_b)
    );

    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs from the cycle index n since reset release (n<0: in reset).
    task automatic check_inst(
        input string pfx, input int n, input int ht, input int vt, input int ha, input int va,
        input int hs0, input int hs1, input int vs0, input int vs1, input int lat,
        input logic [11:0] dprev, input logic psprev,
        input logic [9:0] h, input logic [9:0] v, input logic vld, input logic fs,
        input logic hs, input logic vs, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
        input logic rdy, input logic [MW-1:0] mo, input logic erdy, input logic [MW-1:0] emo);
        int eh, ev, ph, pvv;
        logic evld, efs, ehs, evs;
        logic [11:0] epix;
        if (n < 0) begin
            eh = ht - 1; ev = vt - 1; evld = 1'b0; efs = 1'b0;
        end else begin
            eh = n % ht; ev = (n / ht) % vt;
            evld = (eh < ha) && (ev < va);
            efs = (n % (ht * vt)) == 0;
        end
        epix = 12'h000; ehs = 1'b1; evs = 1'b1;
        if (n >= lat + 1) begin
            ph = (n - 1 - lat) % ht;
            pvv = ((n - 1 - lat) / ht) % vt;
            ehs = !((ph >= hs0) && (ph <= hs1));
            evs = !((pvv >= vs0) && (pvv <= vs1));
            if ((ph < ha) && (pvv < va)) epix = psprev ? bars[ph / 80] : dprev;
        end
        check_val({pfx, "_h_cnt"}, MW'(h), MW'(eh));
        check_val({pfx, "_v_cnt"}, MW'(v), MW'(ev));
        check_val({pfx, "_VGAvalid"}, MW'(vld), MW'(evld));
        check_val({pfx, "_frame_start"}, MW'(fs), MW'(efs));
        check_val({pfx, "_hsync"}, MW'(hs), MW'(ehs));
        check_val({pfx, "_vsync"}, MW'(vs), MW'(evs));
        check_val({pfx, "_rgb"}, MW'({r, g, b}), MW'(epix));
        check_val({pfx, "_ready"}, MW'(rdy), MW'(erdy));
        check_val({pfx, "_mtrxOut"}, mo, emo);
    endtask

    function automatic logic [MW-1:0] rand_mtrx();
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < 11; i++) m = (m << 32) | MW'($urandom);
        return m;
    endfunction

    initial begin
        int n_s, n_f, commits, rst_hold;
        logic pv, cap, commit, dprev, rst_done, seen_se, seen_rp;
        logic [11:0] dp;
        logic ps_prev;
        logic [MW-1:0] pend, mout;
        bit quiet;

        rst_s = 1'b1; rst_f = 1'b1; vga_data = '0; psel = 1'b0;
        s_if.mtrx_in = '0; s_if.mtrx_in_valid = 1'b0;
        f_if.mtrx_in = '0; f_if.mtrx_in_valid = 1'b0;
        n_s = -1; n_f = -1; commits = 0; rst_hold = 0;
        pv = 1'b0; pend = '0; mout = '0;
        rst_done = 1'b0; seen_se = 1'b0; seen_rp = 1'b0;
        dprev = 1'b0;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge pclk);
            #1;
            // Model step using the inputs that were present at this edge.
            dp = vga_data;
            ps_prev = psel;
            cap = s_if.mtrx_in_valid && !pv;
            commit = 1'b0;
            if (rst_s) begin
                n_s = -1; pv = 1'b0; pend = '0; mout = '0;
            end else begin
                n_s++;
                if (n_s % S_FR == S_VA * S_HT) begin
                    commit = 1'b1;
                    commits++;
                    if (pv) begin mout = pend; pv = 1'b0; end
                end
                if (cap) begin
                    pend = s_if.mtrx_in; pv = 1'b1;
                    if (commit) seen_se = 1'b1;
                end
            end
            n_f = rst_f ? -1 : n_f + 1;

            check_inst("s", n_s, S_HT, S_VT, S_HA, S_VA, S_HA + S_HFP, S_HA + S_HFP + S_HS - 1,
                       S_VA + S_VFP, S_VA + S_VFP + S_VS - 1, S_LAT, dp, ps_prev,
                       s_h, s_v, s_vld, s_fs, s_hs, s_vs, s_r, s_g, s_b,
                       s_if.mtrx_in_ready, s_mo, !pv, mout);
            check_inst("f", n_f, F_HT, F_VT, 640, 480, 656, 751, 490, 491, F_LAT, dp, ps_prev,
                       f_h, f_v, f_vld, f_fs, f_hs, f_vs, f_r, f_g, f_b,
                       f_if.mtrx_in_ready, f_mo, 1'b1, '0);

            // Drive inputs for the next cycle.
            vga_data = 12'($urandom);
`ifdef TEST_PATTERN_EN
            psel = ($urandom % 4) == 0;
`endif
            rst_f = (cyc < 2);
            if (!rst_s && cap) s_if.mtrx_in_valid = 1'b0;
            if (rst_hold > 0) begin
                rst_s = 1'b1; rst_hold--;
            end else if (cyc < 2) begin
                rst_s = 1'b1;
            end else if (cyc >= 3500 && !rst_done && pv && n_s >= 0 &&
                         ((n_s / S_HT) % S_VT) >= 3 && ((n_s / S_HT) % S_VT) < S_VA) begin
                rst_s = 1'b1; rst_hold = 1; rst_done = 1'b1; seen_rp = 1'b1;
            end else begin
                rst_s = ($urandom % 5000) == 0;
            end
            // Epochs between commits rotate random / quiet / quiet so that an
            // empty buffer is guaranteed right before some commit edges.
            quiet = (commits % 3) != 0;
            if (!s_if.mtrx_in_valid) begin
                if ((n_s >= 0 && ((n_s + 1) % S_FR == S_VA * S_HT) && !pv) ||
                    (!quiet && ($urandom % 1500) == 0) ||
                    (cyc >= 3500 && !rst_done)) begin
                    s_if.mtrx_in_valid = 1'b1;
                    s_if.mtrx_in = rand_mtrx();
                end
            end
        end

        check_val("same_edge_capture_hit", MW'(seen_se), MW'(1));
        check_val("reset_with_pending_hit", MW'(seen_rp), MW'(1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
